multicycle_controller: RTL
==========================

# multicycle_controller

Control sequencer for the multicycle RV32I core variant. Shares one ALU and one unified instruction/data memory port across the phases of each instruction: fetch, decode, execute, memory and writeback. Sits beside the datapath. Takes the opcode from the instruction register and the ALU `zero` flag. Drives every datapath mux select and write enable, and handshakes with memory through `mem_ready`. The existing ALU decoder still turns `ALUOp` plus funct fields into the ALU control.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op`  in  7  opcode field of the instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in BEQ.
- `mem_ready`  in  1  memory completed the access presented this cycle.
- `PCWrite`  out  1  PC register enable; equals `PCUpdate | (Branch & zero)`.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction/OldPC register enable.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `ALUOp`  out  2  00 = add, 01 = subtract/branch, 10 = funct-decoded.
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `trap`  out  1  illegal opcode seen; core halted.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retire_count`  out  `RETIRE_W`  instructions retired since reset.

## Operation
- States, in 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
- Control signals per state. Any signal not listed is 0 (select fields 00).
  - FETCH: `ALUSrcB`=10, `ResultSrc`=10. Only when `mem_ready`=1: `IRWrite`=1 and `PCUpdate`=1. If `mem_ready`=0, stay in FETCH.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01; computes the branch/jump target.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01.
  - MEMREAD: `AdrSrc`=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWRITE: `AdrSrc`=1, `MemWrite`=1. Hold until `mem_ready`, then go to FETCH.
  - EXECUTER: `ALUSrcA`=10, `ALUOp`=10.
  - EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - ALUWB: `RegWrite`=1.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `PCUpdate`=1, then go to ALUWB.
  - BEQ: `ALUSrcA`=10, `ALUOp`=01, `Branch`=1.
- Transitions out of DECODE, by `op`:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> TRAP
- Other transitions:
  - From MEMADR: to MEMREAD if `op`=0000011, otherwise to MEMWRITE.
  - EXECUTER -> ALUWB. EXECUTEI -> ALUWB.
  - MEMWB, ALUWB and BEQ each go to FETCH.
  - TRAP is absorbing: all enables are 0 and `trap`=1 until reset.
- `ImmSrc` is combinational from `op` in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- `retire` is 1 in the final cycle of an instruction:
  - MEMWB, ALUWB and BEQ;
  - MEMWRITE, only in the cycle where `mem_ready`=1.
- `retire_count` increments on each `retire` and wraps modulo 2^`RETIRE_W`.

## Timing
- All outputs except `ImmSrc` and `PCWrite` are Moore outputs of the registered state, with `mem_ready` qualification where noted above.
- `PCWrite` and the `mem_ready`-gated strobes are combinational from state plus inputs. There is no registered delay.
- While `rst_n`=0: state=FETCH, `retire_count`=0, `trap`=0, `retire`=0.
  - FETCH outputs are driven, but `IRWrite`, `PCUpdate` and `PCWrite` are forced to 0.
  - First fetch strobe: first rising edge after `rst_n` deasserts with `mem_ready`=1.
- Reset asserted mid-instruction returns to FETCH immediately (asynchronous). No partial writeback follows.
- Latency with `mem_ready` tied high:
  - lw: 5 cycles; sw: 4; R-type: 4; I-type ALU: 4; jal: 4; beq: 3.
  - Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `zero` matters only in BEQ. A branch is taken when `zero`=1 in that cycle, giving `PCWrite`=1.

## Test plan
- Reset, then `op`=0110011, `mem_ready`=1 -> states 0,1,6,7,0. `RegWrite`=1 only in ALUWB. `retire_count`=1.
- lw with `mem_ready` low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. `ResultSrc`=01 and `RegWrite`=1 in MEMWB. 7 cycles total.
- sw, `mem_ready`=1 -> `MemWrite`=1 and `AdrSrc`=1 for exactly 1 cycle. `ImmSrc`=01. `RegWrite` never 1.
- beq with `zero`=1, then beq with `zero`=0 -> `PCWrite`=1 in BEQ for the first instruction only. `ALUOp`=01 in both.
- `op`=1111111 -> TRAP after DECODE, `trap`=1. No further `IRWrite` or `RegWrite`. `rst_n` pulse clears `trap` and returns to FETCH.
- jal back-to-back 3 times -> `PCWrite` high in FETCH and JAL. `ImmSrc`=11. `retire_count`=3.

Source files
------------

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Control sequencer for the multicycle RV32I core. One ALU and one unified
// instruction/data memory port are time-shared across the phases of each
// instruction (fetch, decode, execute, memory, writeback). The block sits
// beside the datapath. It reads the opcode from the instruction register and
// the ALU zero flag, and drives every datapath mux select and write enable.
// Memory accesses are held until mem_ready reports completion.
//
// Parameters
//   RETIRE_W      width of the retired-instruction counter
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   op[6:0]       opcode from the instruction register (valid from DECODE)
//   zero          ALU zero flag, used only in BEQ
//   mem_ready     memory finished the access presented this cycle
//   PCWrite       PC register enable (PCUpdate | Branch & zero)
//   AdrSrc        memory address select: 0 = PC, 1 = ALU result register
//   MemWrite      memory write strobe
//   IRWrite       instruction / OldPC register enable
//   RegWrite      register file write enable
//   ResultSrc     result mux: 00 ALUOut, 01 read data, 10 ALU result
//   ALUSrcA       ALU A: 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB       ALU B: 00 rs2, 01 immediate, 10 constant 4
//   ALUOp         00 add, 01 subtract/branch, 10 funct-decoded
//   ImmSrc        immediate format: 00 I, 01 S, 10 B, 11 J
//   trap          illegal opcode seen, core halted until reset
//   retire        one-cycle pulse in the final cycle of an instruction
//   retire_count  instructions retired since reset (wraps)
// ----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          ImmSrc,
  output logic                trap,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_t state;
  state_t nextState;
  logic   pcUpdate;
  logic   branch;
  logic   irWriteRaw;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nextState;
  end

  // Next-state and Moore/mem_ready-qualified outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    nextState  = state;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    irWriteRaw = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    trap       = 1'b0;
    retire     = 1'b0;

    unique case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          irWriteRaw = 1'b1;
          pcUpdate   = 1'b1;
          nextState  = DECODE;
        end
      end
      DECODE: begin
        // Computes OldPC + imm so the branch/jump target is ready in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLoad, OpStore: nextState = MEMADR;
          OpRType:         nextState = EXECUTER;
          OpIType:         nextState = EXECUTEI;
          OpJal:           nextState = JAL;
          OpBranch:        nextState = BEQ;
          default:         nextState = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextState = (op == OpLoad) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) nextState = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        // The store completes, and so retires, only when memory accepts it.
        if (mem_ready) begin
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
      EXECUTER: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b10;
        nextState = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC + 4 for
        // the link value written back in ALUWB.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        nextState = ALUWB;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      TRAP: begin
        trap      = 1'b1;
        nextState = TRAP;
      end
      default: begin
        // Unused encodings can only come from corruption; halt rather than
        // execute with undefined controls.
        nextState = TRAP;
      end
    endcase
  end

  // The fetch strobes are held off while reset is asserted, even though
  // FETCH's other controls are already presented.
  assign IRWrite = irWriteRaw & rst_n;
  assign PCWrite = rst_n & (pcUpdate | (branch & zero));

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_count <= '0;
    else if (retire) retire_count <= retire_count + 1'b1;
  end

endmodule
